// File: rtl/pattern_scan_pkg.sv
// Shared types and constants for the serial pattern scan controller.
//   state_t         : controller FSM state encoding
//   DEFAULT_PATTERN : 4-bit reference pattern (MSB is the first bit seen)
package pattern_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

endpackage

// File: rtl/pattern_scan_ctrl_if.sv
// Word-input handshake between a producer and the scan controller.
//   in_valid : producer has a word
//   in_data  : word to scan, shifted MSB first
//   in_last  : in_data is the final word of the scan
//   in_ready : controller accepts a word this cycle
// master = producer side, slave = controller side.
interface pattern_scan_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/pattern_match_core.sv
// Bit-serial pattern detector: shift history, fill counter and compare.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear_i    : clear history, fill counter and match (start of a scan)
//   bit_en_i   : bit_i is consumed this cycle
//   bit_i      : incoming serial bit
//   pattern_i  : pattern to detect, MSB = oldest bit
//   overlap_i  : 1 = overlapping matches, 0 = non-overlapping
//   hit_o      : combinational, the bit consumed this cycle completes a match
//   match_o    : registered hit_o (one cycle after the bit)
module pattern_match_core #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             bit_en_i,
  input  logic             bit_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic             overlap_i,
  output logic             hit_o,
  output logic             match_o
);

  localparam int FW = $clog2(PAT_W + 1);

  logic [PAT_W-1:0] hist_q, hist_d, hist_shift;
  logic [FW-1:0]    fill_q, fill_d;
  logic             match_q, match_d;

  // Shift form avoids a negative slice when PAT_W is 1.
  assign hist_shift = (hist_q << 1) | PAT_W'(bit_i);
  // Fill already at PAT_W-1 or saturated: this bit makes the window complete.
  assign hit_o = bit_en_i && (fill_q >= FW'(PAT_W - 1)) && (hist_shift == pattern_i);

  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    if (clear_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (bit_en_i) begin
      hist_d  = hist_shift;
      match_d = hit_o;
      // Non-overlap: the next match needs PAT_W fresh bits.
      if (hit_o && !overlap_i) begin
        fill_d = '0;
      end else if (fill_q != FW'(PAT_W)) begin
        fill_d = fill_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
    end
  end

  assign match_o = match_q;

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Sequencer for a programmable serial pattern detector. Accepts words over a
// valid/ready handshake, serialises each MSB first (one bit per clock) into
// pattern_match_core and counts matches per scan.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : begin a scan (accepted only when idle)
//   cfg_pattern  : pattern, latched on accepted start
//   cfg_overlap  : overlap mode, latched on accepted start
//   in_if        : word handshake (slave side)
//   busy         : accepted start through done cycle inclusive
//   match        : one-cycle pulse per detected pattern
//   match_count  : saturating match count since last accepted start
//   done         : one-cycle end-of-scan pulse
module pattern_scan_ctrl
  import pattern_scan_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PAT_W  = 4,
  parameter int CNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [PAT_W-1:0]   cfg_pattern,
  input  logic               cfg_overlap,
  pattern_scan_ctrl_if.slave in_if,
  output logic               busy,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               done
);

  localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              last_q, last_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic              ovl_q, ovl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              core_clear, bit_en, hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    last_d     = last_q;
    bit_cnt_d  = bit_cnt_q;
    pat_d      = pat_q;
    ovl_d      = ovl_q;
    core_clear = 1'b0;
    bit_en     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          pat_d      = cfg_pattern;
          ovl_d      = cfg_overlap;
          core_clear = 1'b1;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        if (in_if.in_valid) begin
          word_d    = in_if.in_data;
          last_d    = in_if.in_last;
          bit_cnt_d = BC_W'(DATA_W - 1);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        bit_en = 1'b1;
        word_d = word_q << 1;
        if (bit_cnt_q == '0) state_d = last_q ? DONE : LOAD;
        else                 bit_cnt_d = bit_cnt_q - 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counter moves on the same edge that registers the match pulse.
  always_comb begin
    cnt_d = cnt_q;
    if (core_clear)                cnt_d = '0;
    else if (hit && cnt_q != '1)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q    <= '0;
      last_q    <= 1'b0;
      bit_cnt_q <= '0;
      pat_q     <= '0;
      ovl_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      word_q    <= word_d;
      last_q    <= last_d;
      bit_cnt_q <= bit_cnt_d;
      pat_q     <= pat_d;
      ovl_q     <= ovl_d;
      cnt_q     <= cnt_d;
    end
  end

  pattern_match_core #(.PAT_W(PAT_W)) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (core_clear),
    .bit_en_i  (bit_en),
    .bit_i     (word_q[DATA_W-1]),
    .pattern_i (pat_q),
    .overlap_i (ovl_q),
    .hit_o     (hit),
    .match_o   (match)
  );

  assign in_if.in_ready = (state_q == LOAD);
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign match_count    = cnt_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
module tb_pattern_scan_ctrl;
  import pattern_scan_pkg::*;

  localparam int DATA_W = 8;
  localparam int PAT_W  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, start, cfg_overlap, in_valid, in_last;
  logic [PAT_W-1:0]  cfg_pattern;
  logic [DATA_W-1:0] in_data;

  logic       busy_a, match_a, done_a, busy_b, match_b, done_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  pattern_scan_ctrl_if #(.DATA_W(DATA_W)) bus_a ();
  pattern_scan_ctrl_if #(.DATA_W(DATA_W)) bus_b ();

  assign bus_a.in_valid = in_valid;
  assign bus_a.in_data  = in_data;
  assign bus_a.in_last  = in_last;
  assign bus_b.in_valid = in_valid;
  assign bus_b.in_data  = in_data;
  assign bus_b.in_last  = in_last;

  pattern_scan_ctrl #(.DATA_W(DATA_W), .PAT_W(PAT_W), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_pattern(cfg_pattern),
    .cfg_overlap(cfg_overlap), .in_if(bus_a.slave), .busy(busy_a),
    .match(match_a), .match_count(cnt_a), .done(done_a));

  // Narrow-counter copy on the same stimulus exercises saturation.
  pattern_scan_ctrl #(.DATA_W(DATA_W), .PAT_W(PAT_W), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_pattern(cfg_pattern),
    .cfg_overlap(cfg_overlap), .in_if(bus_b.slave), .busy(busy_b),
    .match(match_b), .match_count(cnt_b), .done(done_b));

  int checks = 0;
  int failures = 0;

  logic [DATA_W-1:0] wq[$];
  int                stq[$];
  int                exp_m[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: expand words to a bit stream; a match ends at bit i when the
  // last PAT_W bits equal the pattern and, in non-overlap mode, the window
  // does not reuse bits of the previously counted match.
  task automatic build_model(input logic [PAT_W-1:0] pat, input logic ovl);
    logic bits[$];
    logic [PAT_W-1:0] win;
    int last_end = -100;
    exp_m.delete();
    foreach (wq[w]) for (int b = DATA_W - 1; b >= 0; b--) bits.push_back(wq[w][b]);
    foreach (bits[i]) begin
      int m = 0;
      if (i >= PAT_W - 1) begin
        for (int k = 0; k < PAT_W; k++) win[PAT_W-1-k] = bits[i-PAT_W+1+k];
        if (win == pat && (ovl || (i - PAT_W + 1) > last_end)) begin
          m = 1;
          last_end = i;
        end
      end
      exp_m.push_back(m);
    end
  endtask

  task automatic check_cycle(input string tag, input logic rdy, input logic bsy,
                             input logic dn, input logic mt, input int cnt);
    chk({tag, "_ready_a"}, 32'(bus_a.in_ready), 32'(rdy));
    chk({tag, "_ready_b"}, 32'(bus_b.in_ready), 32'(rdy));
    chk({tag, "_busy"},    32'(busy_a), 32'(bsy));
    chk({tag, "_done"},    32'(done_a), 32'(dn));
    chk({tag, "_match_a"}, 32'(match_a), 32'(mt));
    chk({tag, "_match_b"}, 32'(match_b), 32'(mt));
    chk({tag, "_cnt_a"},   32'(cnt_a), (cnt > 255) ? 32'd255 : 32'(cnt));
    chk({tag, "_cnt_b"},   32'(cnt_b), (cnt > 3) ? 32'd3 : 32'(cnt));
    chk({tag, "_busy_b"},  32'(busy_b), 32'(bsy));
    chk({tag, "_done_b"},  32'(done_b), 32'(dn));
  endtask

  // Runs one scan of wq (stall cycles before each word in stq), called at a negedge.
  task automatic run_scan(input string tag, input logic [PAT_W-1:0] pat,
                          input logic ovl, input bit inject_start);
    int   cnt = 0;
    int   gi = 0;
    logic pend = 1'b0;
    build_model(pat, ovl);
    start = 1'b1; cfg_pattern = pat; cfg_overlap = ovl; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; cfg_pattern = PAT_W'($urandom); cfg_overlap = 1'($urandom);
    foreach (wq[w]) begin
      for (int s = 0; s < stq[w]; s++) begin
        in_valid = 1'b0;
        check_cycle({tag, "_stall"}, 1'b1, 1'b1, 1'b0, pend, cnt);
        pend = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1; in_data = wq[w]; in_last = (w == wq.size() - 1);
      check_cycle({tag, "_load"}, 1'b1, 1'b1, 1'b0, pend, cnt);
      pend = 1'b0;
      @(negedge clk);
      for (int b = 0; b < DATA_W; b++) begin
        in_valid = 1'($urandom); in_data = DATA_W'($urandom); in_last = 1'($urandom);
        start = inject_start && (w == 0) && (b == 2);
        check_cycle({tag, "_shift"}, 1'b0, 1'b1, 1'b0, pend, cnt);
        pend = exp_m[gi][0];
        if (pend) cnt++;
        gi++;
        @(negedge clk);
      end
    end
    start = 1'b0; in_valid = 1'b0;
    check_cycle({tag, "_done"}, 1'b0, 1'b1, 1'b1, pend, cnt);
    @(negedge clk);
    in_valid = 1'b1;
    check_cycle({tag, "_idle"}, 1'b0, 1'b0, 1'b0, 1'b0, cnt);
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_pattern = '0; cfg_overlap = 1'b0;
    in_valid = 1'b1; in_data = '1; in_last = 1'b1;
    repeat (2) @(negedge clk);
    check_cycle("rst", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_cycle("idle_valid", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    check_cycle("idle_valid2", 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Basic: two matches in one word
    wq = '{8'b1011_1011}; stq = '{0};
    run_scan("basic", DEFAULT_PATTERN, 1'b1, 1'b0);
    chk("basic_total", 32'(cnt_a), 32'd2);

    // Overlap vs non-overlap
    wq = '{8'b1011_0110}; stq = '{1};
    run_scan("ovl1", DEFAULT_PATTERN, 1'b1, 1'b0);
    chk("ovl1_total", 32'(cnt_a), 32'd2);
    wq = '{8'b1011_0110}; stq = '{0};
    run_scan("ovl0", DEFAULT_PATTERN, 1'b0, 1'b0);
    chk("ovl0_total", 32'(cnt_a), 32'd1);

    // Straddle with a 5-cycle stall between words
    wq = '{8'b0000_0101, 8'b1000_0000}; stq = '{0, 5};
    run_scan("straddle", DEFAULT_PATTERN, 1'b1, 1'b0);
    chk("straddle_total", 32'(cnt_a), 32'd1);

    // Saturation: 13 matches, narrow counter stops at 3
    wq = '{8'hFF, 8'hFF}; stq = '{0, 0};
    run_scan("sat", 4'b1111, 1'b1, 1'b0);
    chk("sat_total_a", 32'(cnt_a), 32'd13);
    chk("sat_total_b", 32'(cnt_b), 32'd3);

    // start during SHIFT must be ignored
    wq = '{8'b1011_1011, 8'b0110_1101}; stq = '{0, 2};
    run_scan("ignstart", DEFAULT_PATTERN, 1'b0, 1'b1);

    // Reset in the middle of SHIFT
    start = 1'b1; cfg_pattern = DEFAULT_PATTERN; cfg_overlap = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 8'b1011_1011; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_cnt", 32'(cnt_a), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_cycle("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wq = '{8'b1011_0000}; stq = '{0};
    run_scan("after_rst", DEFAULT_PATTERN, 1'b1, 1'b0);
    chk("after_rst_total", 32'(cnt_a), 32'd1);

    // Randomised scans
    for (int r = 0; r < 8; r++) begin
      int n = $urandom_range(1, 3);
      wq.delete(); stq.delete();
      for (int w = 0; w < n; w++) begin
        wq.push_back(DATA_W'($urandom));
        stq.push_back($urandom_range(0, 3));
      end
      run_scan("rand", PAT_W'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pattern_scan_ctrl.md
Name: pattern_scan_ctrl

Overview:
Sequencer for a programmable serial pattern detector. Accepts parallel data words over a valid/ready handshake and serialises each word MSB-first into the detector, one bit per clock. Counts detected matches per scan, in either overlapping or non-overlapping mode. Sits between a word-oriented producer and the bit-serial detection datapath, and reports per-bit match pulses, a saturating match count and end-of-scan.

Parameters:
DATA_W, 8, width of each input word (bits serialised per word), >= 1
PAT_W, 4, pattern length in bits, 1..DATA_W*4
CNT_W, 8, width of match counter (saturating)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; begins a scan, ignored unless idle
cfg_pattern  input  PAT_W  pattern to detect, MSB = first bit received; sampled on accepted start
cfg_overlap  input  1  1 = overlapping matches, 0 = non-overlapping; sampled on accepted start
in_valid  input  1  producer has a word
in_data  input  DATA_W  word to scan, shifted MSB first
in_last  input  1  qualifies in_data as final word of the scan
in_ready  output  1  controller accepts a word this cycle
busy  output  1  high from accepted start until done cycle inclusive
match  output  1  one-cycle pulse per detected pattern
match_count  output  CNT_W  matches since last accepted start, saturating
done  output  1  one-cycle pulse marking end of scan

Behaviour:
- Reset (async, any state): FSM to IDLE. Shift history, fill counter, bit counter, latched config, latched last flag, match, match_count and done clear to 0. in_ready and busy read 0.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: start=1 latches cfg_pattern and cfg_overlap, clears history, fill counter and match_count, then goes to LOAD. start in any other state is ignored.
- LOAD: in_ready=1. When in_valid && in_ready, capture in_data and in_last, set bit counter to DATA_W-1 and go to SHIFT. Without in_valid, hold: history is retained and no bits are consumed.
- SHIFT: in_ready=0. Each cycle consumes the current MSB of the captured word:
  - history <= {history[PAT_W-2:0], bit}.
  - fill counter increments, saturating at PAT_W.
- SHIFT exit: after DATA_W cycles, go to DONE if the latched last flag is set, else to LOAD.
- Throughput: DATA_W+1 cycles per word with no stall. History persists across word boundaries, so a pattern may straddle two words.
- Match rule: match_next = (fill counter would reach PAT_W with this bit) && (new history == latched pattern).
  - match is registered: the bit consumed in SHIFT cycle k produces match=1 in cycle k+1.
  - match_count updates on the same edge, +1, holding at 2^CNT_W-1.
- Non-overlap mode: on a match, the fill counter resets to 0, so the next match needs PAT_W fresh bits. Overlap mode leaves the fill counter saturated.
- DONE: one cycle. done=1 and busy=1, then return to IDLE. A match for the final bit can coincide with done.
- match_count holds its value in IDLE until the next accepted start.
- busy = (state != IDLE).
- in_valid, in_data and in_last are ignored outside LOAD.

Decomposition:
- Package pattern_scan_pkg: state enum (IDLE, LOAD, SHIFT, DONE) and default-pattern constant 4'b1011.
- Sub-module pattern_match_core: shift history, fill counter, compare, overlap handling. Inputs are bit, bit_en, clear, pattern and overlap; output is a registered match.
- pattern_scan_ctrl owns the FSM, handshake, word shifter, counter and done logic.

Test Plan:
- Reset and idle: hold rst_n=0, then release. All outputs are 0. in_valid=1 while IDLE leaves in_ready=0.
- Basic scan, pattern 1011, overlap=1, single word 8'b1011_1011 with last:
  - match pulses 1 cycle after bit indices 3 and 7.
  - match_count=2 and done asserts 9 cycles after the handshake.
- Overlap vs non-overlap, pattern 1011, word 8'b1011_0110:
  - overlap=1: matches after bits 3 and 6, count=2.
  - overlap=0: single match after bit 3, count=1.
- Word-boundary straddle, pattern 1011:
  - Send words 8'b0000_0101, then 8'b1000_0000 with last; in_valid held low 5 cycles between them.
  - Exactly one match, on the first bit of word 2; count=1; no bits consumed during the stall.
- Saturation with CNT_W=2, pattern 1111, overlap=1, words 0xFF, 0xFF (last): 13 match pulses, match_count stops at 3.
- Robustness:
  - start pulsed during SHIFT is ignored.
  - rst_n dropped mid-SHIFT: immediately state IDLE and outputs 0.
  - A new start afterwards scans 8'b1011_0000 correctly, count=1.
